// File: rtl/rs232_avm_pkg.sv
// Shared constants and types for the RS232 Avalon-MM byte arbiter.
package rs232_avm_pkg;

    localparam int unsigned RxAddr     = 0;
    localparam int unsigned TxAddr     = 4;
    localparam int unsigned StatusAddr = 8;
    localparam int unsigned RxOkBit    = 7;
    localparam int unsigned TxOkBit    = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POLL = 2'd1,
        S_XFER = 2'd2
    } state_e;

    typedef enum logic {
        G_RX = 1'b0,
        G_TX = 1'b1
    } grant_e;

    function automatic logic [1:0] grant_onehot(grant_e g);
        return (g == G_TX) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rs232_avm_byte_arbiter_if.sv
// Avalon-MM link between the byte arbiter (master) and the UART core (slave).
interface rs232_avm_byte_arbiter_if;

    logic [4:0]  avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata,
        output avm_readdata, avm_waitrequest
    );

endinterface

// File: rtl/rx_watchdog.sv
// Counts consecutive un-acked RX request cycles; pulses expired and restarts at TIMEOUT.
module rx_watchdog #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic avm_clk,
    input  logic avm_rst,
    input  logic req,
    input  logic ack,
    output logic expired
);

    localparam int unsigned Width = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [Width-1:0] Last = Width'(TIMEOUT - 1);

    logic [Width-1:0] count_q;
    logic             expired_q;

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            expired_q <= 1'b0;
            if (!req || ack) begin
                count_q <= '0;
            end else if (count_q == Last) begin
                count_q   <= '0;
                expired_q <= 1'b1;
            end else begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign expired = expired_q;

endmodule

// File: rtl/rs232_avm_byte_arbiter.sv
// Shares the UART Avalon-MM master between the RX and TX byte requesters,
// hiding status polling and waitrequest behind per-requester req/ack.
module rs232_avm_byte_arbiter
    import rs232_avm_pkg::*;
#(
    parameter int unsigned RX_ADDR     = RxAddr,
    parameter int unsigned TX_ADDR     = TxAddr,
    parameter int unsigned STATUS_ADDR = StatusAddr,
    parameter int unsigned RX_OK_BIT   = RxOkBit,
    parameter int unsigned TX_OK_BIT   = TxOkBit,
    parameter int unsigned RX_TIMEOUT  = 268435455
) (
    input  logic                            avm_clk,
    input  logic                            avm_rst,
    rs232_avm_byte_arbiter_if.master        avm,
    input  logic                            rx_req,
    output logic                            rx_ack,
    output logic [7:0]                      rx_data,
    output logic                            rx_timeout,
    input  logic                            tx_req,
    input  logic [7:0]                      tx_data,
    output logic                            tx_ack,
    output logic [1:0]                      grant_o,
    output logic [1:0]                      state_o
);

    localparam logic [4:0] RxA    = 5'(RX_ADDR);
    localparam logic [4:0] TxA    = 5'(TX_ADDR);
    localparam logic [4:0] StatA  = 5'(STATUS_ADDR);
    localparam logic [4:0] RxOkIx = 5'(RX_OK_BIT);
    localparam logic [4:0] TxOkIx = 5'(TX_OK_BIT);

    state_e      state_q;
    grant_e      grant_q;
    grant_e      last_grant_q;
    logic [4:0]  address_q;
    logic        read_q;
    logic        write_q;
    logic [31:0] writedata_q;
    logic [7:0]  rx_data_q;
    logic        rx_ack_q;
    logic        tx_ack_q;

    logic rx_pend, tx_pend, own_req, other_req, own_ok;

    // The requester acked last cycle is masked so the other one can win IDLE.
    always_comb begin
        rx_pend   = rx_req & ~rx_ack_q;
        tx_pend   = tx_req & ~tx_ack_q;
        own_req   = (grant_q == G_TX) ? tx_req : rx_req;
        other_req = (grant_q == G_TX) ? rx_req : tx_req;
        own_ok    = (grant_q == G_TX) ? avm.avm_readdata[TxOkIx] : avm.avm_readdata[RxOkIx];
    end

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            state_q      <= S_IDLE;
            grant_q      <= G_RX;
            last_grant_q <= G_TX;
            address_q    <= StatA;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            writedata_q  <= '0;
            rx_data_q    <= '0;
            rx_ack_q     <= 1'b0;
            tx_ack_q     <= 1'b0;
        end else begin
            rx_ack_q <= 1'b0;
            tx_ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rx_pend || tx_pend) begin
                        if (rx_pend && (!tx_pend || last_grant_q == G_TX)) begin
                            grant_q <= G_RX;
                        end else begin
                            grant_q     <= G_TX;
                            writedata_q <= {24'b0, tx_data};
                        end
                        read_q    <= 1'b1;
                        address_q <= StatA;
                        state_q   <= S_POLL;
                    end
                end
                S_POLL: begin
                    if (!avm.avm_waitrequest) begin
                        if (!own_req) begin
                            read_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else if (own_ok) begin
                            state_q <= S_XFER;
                            if (grant_q == G_RX) begin
                                address_q <= RxA;
                            end else begin
                                read_q    <= 1'b0;
                                write_q   <= 1'b1;
                                address_q <= TxA;
                            end
                        end else if (other_req) begin
                            last_grant_q <= grant_q;
                            read_q       <= 1'b0;
                            state_q      <= S_IDLE;
                        end
                        // Otherwise the status read is simply reissued.
                    end
                end
                S_XFER: begin
                    if (!avm.avm_waitrequest) begin
                        read_q       <= 1'b0;
                        write_q      <= 1'b0;
                        address_q    <= StatA;
                        last_grant_q <= grant_q;
                        state_q      <= S_IDLE;
                        if (grant_q == G_RX) begin
                            rx_data_q <= avm.avm_readdata[7:0];
                            rx_ack_q  <= 1'b1;
                        end else begin
                            tx_ack_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    rx_watchdog #(
        .TIMEOUT (RX_TIMEOUT)
    ) u_rx_watchdog (
        .avm_clk (avm_clk),
        .avm_rst (avm_rst),
        .req     (rx_req),
        .ack     (rx_ack_q),
        .expired (rx_timeout)
    );

    assign avm.avm_address   = address_q;
    assign avm.avm_read      = read_q;
    assign avm.avm_write     = write_q;
    assign avm.avm_writedata = writedata_q;
    assign rx_ack            = rx_ack_q;
    assign rx_data           = rx_data_q;
    assign tx_ack            = tx_ack_q;
    assign grant_o           = (state_q == S_IDLE) ? 2'b00 : grant_onehot(grant_q);
    assign state_o           = state_q;

endmodule

// File: tb/tb_rs232_avm_byte_arbiter.sv
// Self-checking bench: UART slave model plus scoreboards for RX bytes and TX writes.
module tb_rs232_avm_byte_arbiter;

    logic avm_clk = 1'b0;
    logic avm_rst = 1'b1;
    always #5 avm_clk = ~avm_clk;

    rs232_avm_byte_arbiter_if bif ();

    logic       rx_req = 1'b0;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_timeout;
    logic       tx_req = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ack;
    logic [1:0] grant_o;
    logic [1:0] state_o;

    rs232_avm_byte_arbiter #(
        .RX_TIMEOUT (16)
    ) dut (
        .avm_clk    (avm_clk),
        .avm_rst    (avm_rst),
        .avm        (bif),
        .rx_req     (rx_req),
        .rx_ack     (rx_ack),
        .rx_data    (rx_data),
        .rx_timeout (rx_timeout),
        .tx_req     (tx_req),
        .tx_data    (tx_data),
        .tx_ack     (tx_ack),
        .grant_o    (grant_o),
        .state_o    (state_o)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge avm_clk) cyc <= cyc + 1;

    // Stimulus knobs and scoreboards
    logic [7:0] rx_fifo[$];
    logic [7:0] rx_exp[$];
    logic [7:0] tx_exp[$];
    logic [7:0] status_q[$];
    logic [7:0] status_dflt = 8'hC0;
    bit         random_mode = 1'b0;
    bit         stall_rx_forever = 1'b0;
    int         stall_max = 0;
    int         write_stall = -1;

    logic [5:0] bus_log[$];
    int         xfer_log[$];
    int         to_log[$];
    int rx_ack_cnt = 0, tx_ack_cnt = 0, rx_reads = 0, tx_writes = 0;
    int polls = 0, rx_fail_polls = 0, write_stall_seen = 0, rx_ack_cyc = 0;

    bit          busy = 1'b0;
    int          stall_left = 0, stall_cnt = 0;
    logic [4:0]  s_addr;
    logic        s_rd, s_wr;
    logic [31:0] s_wd;
    bit          last_was_status = 1'b0;
    logic [7:0]  last_status = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic complete_xfer();
        logic [7:0] st;
        bus_log.push_back({bif.avm_write, bif.avm_address});
        if (bif.avm_read && bif.avm_address == 5'd8) begin
            if (status_q.size() > 0) st = status_q.pop_front();
            else if (random_mode)
                st = {1'(rx_fifo.size() > 0 && $urandom_range(0, 1) == 1),
                      1'($urandom_range(0, 1)), 6'b0};
            else st = status_dflt;
            bif.avm_readdata = {24'h0, st};
            polls++;
            if (grant_o == 2'b01 && !st[7]) rx_fail_polls++;
            check("poll_owner_onehot", 32'(grant_o == 2'b01 || grant_o == 2'b10), 1);
            last_was_status = 1'b1;
            last_status     = st;
        end else if (bif.avm_read && bif.avm_address == 5'd0) begin
            check("rx_read_after_ok_poll", {last_was_status, last_status[7]}, 2'b11);
            check("rx_read_owner", grant_o, 2'b01);
            check("rx_fifo_nonempty", 32'(rx_fifo.size() > 0), 1);
            bif.avm_readdata = {$urandom_range(0, 16777215), 8'h00};
            if (rx_fifo.size() > 0) bif.avm_readdata[7:0] = rx_fifo.pop_front();
            rx_reads++;
            xfer_log.push_back(0);
            last_was_status = 1'b0;
        end else if (bif.avm_write && bif.avm_address == 5'd4) begin
            check("tx_write_after_ok_poll", {last_was_status, last_status[6]}, 2'b11);
            check("tx_write_owner", grant_o, 2'b10);
            if (tx_exp.size() > 0) check("tx_writedata", bif.avm_writedata, {24'h0, tx_exp.pop_front()});
            else check("tx_exp_pending", tx_exp.size(), 1);
            tx_writes++;
            write_stall_seen = stall_cnt;
            xfer_log.push_back(1);
            last_was_status = 1'b0;
        end else begin
            check("bus_access_legal", {bif.avm_write, bif.avm_address}, 6'h08);
        end
    endtask

    // UART slave: drives waitrequest/readdata at negedge, completes at the next posedge.
    always @(negedge avm_clk) begin
        if (avm_rst) begin
            busy = 1'b0;
            bif.avm_waitrequest = 1'b0;
        end else if (bif.avm_read || bif.avm_write) begin
            check("one_strobe", 32'(bif.avm_read & bif.avm_write), 0);
            if (!busy) begin
                busy = 1'b1;
                s_addr = bif.avm_address; s_rd = bif.avm_read;
                s_wr = bif.avm_write; s_wd = bif.avm_writedata;
                stall_cnt = 0;
                if (stall_rx_forever && bif.avm_read && bif.avm_address == 5'd0) stall_left = 1000000;
                else if (bif.avm_write && write_stall >= 0) stall_left = write_stall;
                else stall_left = $urandom_range(0, stall_max);
            end else begin
                check("hold_addr_strobes", {bif.avm_address, bif.avm_read, bif.avm_write},
                      {s_addr, s_rd, s_wr});
                check("hold_writedata", bif.avm_writedata, s_wd);
            end
            if (stall_left > 0) begin
                bif.avm_waitrequest = 1'b1;
                bif.avm_readdata = $urandom;
                stall_left--;
                stall_cnt++;
            end else begin
                bif.avm_waitrequest = 1'b0;
                busy = 1'b0;
                complete_xfer();
            end
        end else begin
            busy = 1'b0;
            bif.avm_waitrequest = random_mode ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Response monitor
    always @(negedge avm_clk) begin
        if (!avm_rst) begin
            if (rx_ack) begin
                rx_ack_cnt++;
                rx_ack_cyc = cyc;
                check("rx_ack_follows_read", rx_reads, rx_ack_cnt);
                if (rx_exp.size() > 0) check("rx_data", rx_data, rx_exp.pop_front());
                else check("rx_exp_pending", rx_exp.size(), 1);
            end
            if (tx_ack) begin
                tx_ack_cnt++;
                check("tx_ack_follows_write", tx_writes, tx_ack_cnt);
            end
            if (rx_timeout) to_log.push_back(cyc);
        end
    end

    task automatic wait_rx_ack(input int start, input string name);
        bit got;
        got = 1'b0;
        for (int c = 0; c < 3000 && !got; c++) begin
            @(posedge avm_clk); #1;
            if (rx_ack_cnt > start) got = 1'b1;
        end
        check(name, 32'(got), 1);
    endtask

    task automatic wait_tx_ack(input int start, input string name);
        bit got;
        got = 1'b0;
        for (int c = 0; c < 3000 && !got; c++) begin
            @(posedge avm_clk); #1;
            if (tx_ack_cnt > start) got = 1'b1;
        end
        check(name, 32'(got), 1);
    endtask

    task automatic rx_take(input int n, input int gap_max);
        int start, gap;
        for (int i = 0; i < n; i++) begin
            start  = rx_ack_cnt;
            rx_req = 1'b1;
            wait_rx_ack(start, "rx_ack_in_time");
            gap = $urandom_range(0, gap_max);
            if (gap > 0) begin
                rx_req = 1'b0;
                repeat (gap) @(posedge avm_clk);
                #1;
            end
        end
        rx_req = 1'b0;
    endtask

    task automatic tx_send(input int n, input int gap_max, input int fixed);
        int start, gap;
        for (int i = 0; i < n; i++) begin
            start   = tx_ack_cnt;
            tx_data = (fixed >= 0) ? 8'(fixed) : 8'($urandom);
            tx_exp.push_back(tx_data);
            tx_req  = 1'b1;
            wait_tx_ack(start, "tx_ack_in_time");
            gap = $urandom_range(0, gap_max);
            if (gap > 0) begin
                tx_req = 1'b0;
                repeat (gap) @(posedge avm_clk);
                #1;
            end
        end
        tx_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge avm_clk); #2;
        avm_rst = 1'b1;
        repeat (2) @(posedge avm_clk);
        #1 avm_rst = 1'b0;
        @(posedge avm_clk); #1;
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        int c0, c1, snap;
        bit found;
        bif.avm_waitrequest = 1'b0;
        bif.avm_readdata    = '0;

        // Reset values
        repeat (3) @(posedge avm_clk);
        #1;
        check("rst_strobes", {bif.avm_read, bif.avm_write}, 2'b00);
        check("rst_address", bif.avm_address, 5'd8);
        check("rst_writedata", bif.avm_writedata, 32'h0);
        check("rst_acks_timeout", {rx_ack, tx_ack, rx_timeout}, 3'b000);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_grant_state", {grant_o, state_o}, 4'h0);
        avm_rst = 1'b0;
        @(posedge avm_clk); #1;

        // RX only, minimum latency
        status_dflt = 8'h80;
        rx_fifo.push_back(8'h5A); rx_exp.push_back(8'h5A);
        bus_log.delete();
        c0 = cyc;
        rx_take(1, 0);
        check("rx_latency", rx_ack_cyc - c0, 3);
        check("rx_bus_count", bus_log.size(), 2);
        if (bus_log.size() == 2) begin
            check("rx_bus_first", bus_log[0], {1'b0, 5'd8});
            check("rx_bus_second", bus_log[1], {1'b0, 5'd0});
        end

        // TX with failing polls and a stalled write
        status_q = '{8'h00, 8'h00, 8'h00, 8'h00};
        status_dflt = 8'h40;
        write_stall = 2;
        polls = 0;
        snap = tx_writes;
        tx_send(1, 0, 8'hC3);
        check("tx_poll_count", polls, 5);
        check("tx_single_write", tx_writes - snap, 1);
        check("tx_write_stall", write_stall_seen, 2);
        write_stall = -1;

        // Both requesters from reset alternate RX, TX, RX, TX
        do_reset();
        status_dflt = 8'hC0;
        xfer_log.delete();
        for (int i = 0; i < 2; i++) begin
            rx_fifo.push_back(8'(8'h10 + i)); rx_exp.push_back(8'(8'h10 + i));
        end
        fork
            rx_take(2, 0);
            tx_send(2, 0, -1);
        join
        check("alt_count", xfer_log.size(), 4);
        if (xfer_log.size() == 4)
            check("alt_order", {xfer_log[0][0], xfer_log[1][0], xfer_log[2][0], xfer_log[3][0]},
                  4'b0101);

        // RX not ready yields to TX
        status_dflt = 8'h40;
        rx_fifo.push_back(8'h3C); rx_exp.push_back(8'h3C);
        rx_fail_polls = 0;
        snap = rx_ack_cnt;
        rx_req = 1'b1;
        tx_send(1, 0, -1);
        repeat (20) @(posedge avm_clk);
        #1;
        check("yield_rx_not_acked", rx_ack_cnt, snap);
        check("yield_rx_polls_failed", 32'(rx_fail_polls > 0), 1);
        status_dflt = 8'hC0;
        wait_rx_ack(snap, "yield_rx_served_later");
        rx_req = 1'b0;
        @(posedge avm_clk); #1;

        // RX watchdog
        status_dflt = 8'h00;
        snap = rx_ack_cnt;
        to_log.delete();
        c0 = cyc;
        rx_req = 1'b1;
        repeat (40) @(posedge avm_clk);
        #1;
        check("wd_pulse_count", to_log.size(), 2);
        if (to_log.size() == 2) begin
            check("wd_first_pulse", to_log[0] - c0, 16);
            check("wd_second_pulse", to_log[1] - c0, 32);
        end
        rx_req = 1'b0;
        repeat (3) @(posedge avm_clk);
        #1;
        to_log.delete();
        c1 = cyc;
        rx_req = 1'b1;
        repeat (20) @(posedge avm_clk);
        #1;
        check("wd_restart_count", to_log.size(), 1);
        if (to_log.size() == 1) check("wd_restart_pulse", to_log[0] - c1, 16);
        check("wd_no_rx_ack", rx_ack_cnt, snap);
        rx_req = 1'b0;
        status_dflt = 8'hC0;
        repeat (4) @(posedge avm_clk);
        #1;

        // Randomised traffic with stalls and random status
        random_mode = 1'b1;
        stall_max = 3;
        for (int i = 0; i < 25; i++) begin
            c1 = $urandom_range(0, 255);
            rx_fifo.push_back(8'(c1)); rx_exp.push_back(8'(c1));
        end
        fork
            rx_take(25, 3);
            tx_send(25, 3, -1);
        join
        check("rand_rx_drained", rx_exp.size(), 0);
        check("rand_tx_drained", tx_exp.size(), 0);
        random_mode = 1'b0;
        stall_max = 0;
        repeat (3) @(posedge avm_clk);
        #1;

        // Reset during a stalled RX transfer
        status_dflt = 8'h80;
        rx_fifo.push_back(8'h77); rx_exp.push_back(8'h77);
        stall_rx_forever = 1'b1;
        snap = rx_ack_cnt;
        rx_req = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge avm_clk);
            if (bif.avm_read && bif.avm_address == 5'd0 && state_o == 2'd2) found = 1'b1;
        end
        check("rst_mid_xfer_reached", 32'(found), 1);
        #2 avm_rst = 1'b1;
        #1;
        check("rst_async_strobes", {bif.avm_read, bif.avm_write}, 2'b00);
        check("rst_async_addr_state", {bif.avm_address, state_o}, {5'd8, 2'd0});
        rx_req = 1'b0;
        repeat (2) @(posedge avm_clk);
        #1 avm_rst = 1'b0;
        stall_rx_forever = 1'b0;
        repeat (5) @(posedge avm_clk);
        #1;
        check("rst_no_rx_ack", rx_ack_cnt, snap);
        check("rst_rx_data_cleared", rx_data, 8'h00);
        status_dflt = 8'hC0;
        fork
            rx_take(1, 0);
            tx_send(1, 0, -1);
            begin
                found = 1'b0;
                for (int c = 0; c < 20 && !found; c++) begin
                    @(negedge avm_clk);
                    if (grant_o != 2'b00) found = 1'b1;
                end
                check("rst_first_grant_rx", grant_o, 2'b01);
            end
        join
        check("final_rx_drained", rx_exp.size(), 0);

        repeat (5) @(posedge avm_clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
